// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB requester
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

   localparam int APB_ADDR_W = 8;
   localparam int APB_DATA_W = 8;

   localparam logic [APB_ADDR_W-1:0] TCR_ADDR = 8'h00;
   localparam logic [APB_ADDR_W-1:0] TSR_ADDR = 8'h01;
   localparam logic [APB_ADDR_W-1:0] TDR_ADDR = 8'h02;

endpackage

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-beat command to APB3 transfer requester with wait-state timeout
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int DATA_W  = APB_DATA_W,
   parameter int TIMEOUT = 16
) (
   input  logic              pclk,
   input  logic              preset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   // A zero TIMEOUT still needs a legal one-bit counter; it simply saturates unused.
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit TO_EN = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   apb_state_t       state;
   logic [CNT_W-1:0] wait_cnt;

   assign cmd_ready = (state == IDLE);

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state       <= IDLE;
         psel        <= 1'b0;
         penable     <= 1'b0;
         pwrite      <= 1'b0;
         paddr       <= '0;
         pwdata      <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         wait_cnt    <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  paddr    <= cmd_addr;
                  pwrite   <= cmd_write;
                  pwdata   <= cmd_write ? cmd_wdata : '0;
                  psel     <= 1'b1;
                  wait_cnt <= '0;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               penable <= 1'b1;
               state   <= ACCESS;
            end
            ACCESS: begin
               // pready has priority over the abort on the last permitted wait cycle.
               if (pready) begin
                  rsp_rdata   <= (!pwrite && !pslverr) ? prdata : '0;
                  rsp_err     <= pslverr;
                  rsp_timeout <= 1'b0;
                  rsp_valid   <= 1'b1;
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  state       <= IDLE;
               end else if (TO_EN && (wait_cnt == CNT_LAST)) begin
                  rsp_rdata   <= '0;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
                  rsp_valid   <= 1'b1;
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  state       <= IDLE;
               end else if (wait_cnt != CNT_MAX) begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            default: begin
               psel    <= 1'b0;
               penable <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - randomized self-checking bench for apb_master against a transaction-level model
module tb_apb_master;
   import apb_pkg::*;

   localparam int TO = 4;

   logic       pclk = 1'b0;
   logic       preset_n;
   logic       cmd_valid, cmd_ready, cmd_write;
   logic [7:0] cmd_addr, cmd_wdata;
   logic       rsp_valid, rsp_err, rsp_timeout;
   logic [7:0] rsp_rdata;
   logic       psel, penable, pwrite;
   logic [7:0] paddr, pwdata, prdata;
   logic       pready, pslverr;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // responder knobs and its register storage
   int         wait_n = 1;
   bit         stale  = 1'b0;
   int         acc_cnt = 0;
   logic [7:0] mem [0:2];

   // scoreboard view of the timer registers
   logic [7:0] exp_mem [0:2];

   apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
      .pclk(pclk), .preset_n(preset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .rsp_timeout(rsp_timeout),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 pclk = ~pclk;
   always @(posedge pclk) cyc++;

   // Responder: ready after wait_n ACCESS cycles, error outside TCR..TDR.
   always @(negedge pclk) begin
      if (psel && penable) begin
         if (acc_cnt == wait_n) begin
            pready  = 1'b1;
            pslverr = (paddr > TDR_ADDR);
            prdata  = (paddr <= TDR_ADDR && !pwrite) ? mem[paddr[1:0]] : 8'hEE;
            if (pwrite && paddr <= TDR_ADDR) mem[paddr[1:0]] = pwdata;
         end else begin
            pready  = 1'b0;
            pslverr = 1'($urandom);
            prdata  = 8'($urandom);
         end
         acc_cnt++;
      end else begin
         acc_cnt = 0;
         pready  = stale;
         pslverr = stale;
         prdata  = 8'($urandom);
      end
   end

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_cmd(input logic wr, input logic [7:0] a, input logic [7:0] d,
                         input int wn, input bit stale_in);
      int         exp_c;
      logic       exp_to, exp_err;
      logic [7:0] exp_rd;
      bit         seen;
      wait_n  = wn;
      stale   = stale_in;
      exp_to  = (wn >= TO);
      exp_c   = exp_to ? TO + 2 : 3 + wn;
      exp_err = exp_to || (a > TDR_ADDR);
      exp_rd  = (!wr && !exp_err) ? exp_mem[a[1:0]] : 8'h00;
      if (wr && !exp_err) exp_mem[a[1:0]] = d;
      @(negedge pclk);
      check("idle_ready", int'(cmd_ready), 1);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
      @(posedge pclk);
      #1;
      // garbage held on the command port while busy must be ignored
      cmd_write = 1'($urandom); cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom);
      seen = 1'b0;
      for (int c = 1; c <= 40 && !seen; c++) begin
         @(negedge pclk);
         if (rsp_valid) begin
            seen = 1'b1;
            cmd_valid = 1'b0;
            check("rsp_cycle", c, exp_c);
            check("rsp_rdata", int'(rsp_rdata), int'(exp_rd));
            check("rsp_err", int'(rsp_err), int'(exp_err));
            check("rsp_timeout", int'(rsp_timeout), int'(exp_to));
            check("rsp_psel", int'(psel), 0);
            check("rsp_ready", int'(cmd_ready), 1);
         end else begin
            check("busy_psel", int'(psel), 1);
            check("busy_penable", int'(penable), int'(c >= 2));
            check("busy_ready", int'(cmd_ready), 0);
            check("hold_paddr", int'(paddr), int'(a));
            check("hold_pwrite", int'(pwrite), int'(wr));
            check("hold_pwdata", int'(pwdata), wr ? int'(d) : 0);
         end
      end
      cmd_valid = 1'b0;
      if (!seen) check("rsp_seen", 0, 1);
      @(negedge pclk);
      check("rsp_pulse", int'(rsp_valid), 0);
      check("after_psel", int'(psel), 0);
      check("hold_rsp_err", int'(rsp_err), int'(exp_err));
   endtask

   task automatic queued();
      int         acc_cyc [$];
      logic [7:0] qd [3];
      int         k = 0;
      int         n_rsp = 0;
      wait_n = 1;
      stale  = 1'b0;
      for (int i = 0; i < 3; i++) qd[i] = 8'($urandom);
      for (int c = 0; c < 40 && n_rsp < 3; c++) begin
         @(negedge pclk);
         if (rsp_valid) begin
            n_rsp++;
            check("q_rsp_err", int'(rsp_err), 0);
         end
         if (psel) check("q_busy_ready", int'(cmd_ready), 0);
         if (cmd_ready && k < 3) begin
            cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'(k); cmd_wdata = qd[k];
            exp_mem[k] = qd[k];
            acc_cyc.push_back(cyc);
            k++;
         end else if (cmd_ready) begin
            cmd_valid = 1'b0;
         end
      end
      cmd_valid = 1'b0;
      check("q_rsp_count", n_rsp, 3);
      check("q_accepts", acc_cyc.size(), 3);
      if (acc_cyc.size() == 3) begin
         check("q_gap1", acc_cyc[1] - acc_cyc[0], 4);
         check("q_gap2", acc_cyc[2] - acc_cyc[1], 4);
      end
      for (int i = 0; i < 3; i++) do_cmd(1'b0, 8'(i), 8'h00, 1, 1'b0);
   endtask

   task automatic reset_mid_access();
      wait_n = 255;
      stale  = 1'b0;
      @(negedge pclk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = TSR_ADDR; cmd_wdata = 8'h5A;
      @(negedge pclk);
      cmd_valid = 1'b0;
      repeat (2) @(negedge pclk);
      check("rst_in_access", int'(penable), 1);
      #2;
      preset_n = 1'b0;
      #1;
      check("rst_psel", int'(psel), 0);
      check("rst_penable", int'(penable), 0);
      check("rst_ready", int'(cmd_ready), 1);
      check("rst_rsp", int'(rsp_valid), 0);
      repeat (2) begin
         @(negedge pclk);
         check("rst_no_rsp", int'(rsp_valid), 0);
      end
      preset_n = 1'b1;
      do_cmd(1'b0, TSR_ADDR, 8'h00, 1, 1'b0);
   endtask

   initial begin
      preset_n = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      pready = 1'b0; pslverr = 1'b0; prdata = '0;
      for (int i = 0; i < 3; i++) begin
         mem[i]     = 8'h00;
         exp_mem[i] = 8'h00;
      end
      #12;
      check("reset_psel", int'(psel), 0);
      check("reset_penable", int'(penable), 0);
      check("reset_pwrite", int'(pwrite), 0);
      check("reset_paddr", int'(paddr), 0);
      check("reset_pwdata", int'(pwdata), 0);
      check("reset_rsp_valid", int'(rsp_valid), 0);
      check("reset_rsp_rdata", int'(rsp_rdata), 0);
      check("reset_rsp_err", int'(rsp_err), 0);
      check("reset_rsp_timeout", int'(rsp_timeout), 0);
      check("reset_cmd_ready", int'(cmd_ready), 1);
      @(negedge pclk);
      preset_n = 1'b1;

      do_cmd(1'b1, TCR_ADDR, 8'h35, 1, 1'b0);
      do_cmd(1'b0, TCR_ADDR, 8'h00, 1, 1'b0);
      do_cmd(1'b0, 8'h05, 8'h00, 1, 1'b0);
      do_cmd(1'b1, TSR_ADDR, 8'hA7, 0, 1'b1);
      do_cmd(1'b0, TSR_ADDR, 8'h00, 3, 1'b0);
      do_cmd(1'b0, TDR_ADDR, 8'h00, 255, 1'b0);
      queued();
      reset_mid_access();

      for (int i = 0; i < 40; i++)
         do_cmd(1'($urandom), 8'($urandom_range(0, 4)), 8'($urandom),
                int'($urandom_range(0, 6)), 1'($urandom));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/apb_master.md
# apb_master

APB requester that turns single-beat register commands into APB3 transfers toward the timer register block (TCR 0x00, TSR 0x01, TDR 0x02). It sits between the firmware-facing command port (CPU bridge or test sequencer) and the APB bus, sequences SETUP/ACCESS phases, honours `pready` wait states and returns read data plus error status. A bounded wait-state timeout keeps a missing responder from hanging the bus.

## Interface
- `ADDR_W`, 8, width of `cmd_addr` and `paddr`
- `DATA_W`, 8, width of write/read data
- `TIMEOUT`, 16, maximum ACCESS cycles without `pready` before abort; 0 disables the timeout

- `pclk`  in  1  bus clock; all logic is on the rising edge
- `preset_n`  in  1  asynchronous active-low reset
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_addr`  in  ADDR_W  target address
- `cmd_wdata`  in  DATA_W  write data
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_rdata`  out  DATA_W  read data; 0 for writes, errors and timeouts
- `rsp_err`  out  1  `pslverr` was sampled high, or the transfer timed out
- `rsp_timeout`  out  1  the transfer was aborted by the timeout
- `psel`, `penable`, `pwrite`  out  1  APB control
- `paddr`  out  ADDR_W  APB address
- `pwdata`  out  DATA_W  APB write data
- `prdata`  in  DATA_W  APB read data
- `pready`  in  1  APB ready
- `pslverr`  in  1  APB slave error

## Operation
- The FSM has three states: IDLE, SETUP and ACCESS. All APB outputs are registered.
- **IDLE**
  - `cmd_ready` = 1 and `psel` = `penable` = 0.
  - On accept, latch `paddr`/`pwrite`/`pwdata` from the command, set `psel` = 1, clear the wait counter and go to SETUP.
  - On a read, `pwdata` is set to 0.
- **SETUP**
  - `psel` = 1, `penable` = 0.
  - Unconditionally go to ACCESS with `penable` = 1.
  - `pready` is ignored in this state.
- **ACCESS**
  - `psel` = `penable` = 1. `paddr`, `pwrite` and `pwdata` are held stable.
  - If `pready` = 1: capture `rsp_rdata` (`prdata` if read, else 0) and `rsp_err` = `pslverr`; pulse `rsp_valid`; drop `psel`/`penable`; go to IDLE.
  - Else, if `TIMEOUT` != 0 and the wait counter = `TIMEOUT`-1: abort with `rsp_valid` = 1, `rsp_err` = 1, `rsp_timeout` = 1, `rsp_rdata` = 0; go to IDLE.
  - Else increment the wait counter.
- `pready` is sampled only in ACCESS. A stale `pready` in IDLE or SETUP (for example from a registered-ready responder) has no effect.
- `rsp_rdata`, `rsp_err` and `rsp_timeout` are held until the next `rsp_valid`. There is no response backpressure: the consumer must take the pulse.
- The wait counter is `$clog2(TIMEOUT+1)` bits, saturating, and is cleared on every accept.
- `cmd_*` inputs are ignored when `cmd_ready` = 0.

## Timing
- Reset (async, immediate):
  - state = IDLE.
  - `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `rsp_valid`, `rsp_rdata`, `rsp_err`, `rsp_timeout` = 0.
  - `cmd_ready` = 1, since it is decoded from IDLE.
- Reset during SETUP or ACCESS abandons the transfer: the bus drops in the same instant and no `rsp_valid` is issued.
- Accept at edge 0 → SETUP in cycle 1 → ACCESS from cycle 2.
- With a zero-wait responder, `rsp_valid` is high in cycle 3. Each wait state adds one cycle.
- The timer register block asserts `pready` one cycle into ACCESS, so `rsp_valid` is high in cycle 4.
- `cmd_ready` returns high in the same cycle as `rsp_valid`. Minimum spacing is 3 cycles between accepts with zero-wait, or 4 with the timer block.
- Timeout: `rsp_valid` is high exactly `TIMEOUT`+2 cycles after accept when `pready` never rises. A `pready` arriving on the abort cycle is ignored.

## Structure
- Shared package `apb_pkg`:
  - state enum type `apb_state_t` with values IDLE/SETUP/ACCESS;
  - default widths `APB_ADDR_W` = 8 and `APB_DATA_W` = 8;
  - timer register address constants `TCR_ADDR` = 0, `TSR_ADDR` = 1, `TDR_ADDR` = 2.
- Single module; no sub-module. The wait counter is inline.

## Test plan
- Write 0x35 to 0x00 against the timer register block:
  - `psel` rises cycle 1, `penable` rises cycle 2, `pready` cycle 3, `rsp_valid` cycle 4 with `rsp_err` = 0;
  - reading back 0x00 returns `rsp_rdata` = 0x35.
- Read 0x05 (out of range) from the timer register block → `rsp_valid` with `rsp_err` = 1, `rsp_timeout` = 0, `rsp_rdata` = 0.
- Responder model holds `pready` low 3 cycles, then returns `prdata` = 0xA7:
  - `paddr`/`pwrite`/`pwdata` are stable throughout ACCESS;
  - `rsp_rdata` = 0xA7 in cycle 6.
- `TIMEOUT` = 4 and `pready` tied low → `rsp_valid` at cycle 6 with `rsp_err` = 1, `rsp_timeout` = 1; `psel` = 0 the following cycle.
- `cmd_valid` held high with 3 queued commands → accepts exactly 4 cycles apart against the timer block; `cmd_ready` = 0 in SETUP and ACCESS.
- `preset_n` pulsed low during ACCESS → `psel`/`penable` = 0 immediately, no `rsp_valid`, `cmd_ready` = 1; a new command then completes normally.
